// File: rtl/pcm_sample_feeder.sv
// PCM sample feeder: stereo FIFO, prefill-gated FIR start, one pop per interpolation period.
// Optional HOLD_LAST_EN: on underrun keep the previous sample instead of outputting zero.
module pcm_sample_feeder #(
  parameter int DEPTH_LOG2     = 4,
  parameter int PREFILL        = 8,
  parameter int STOP_UNDERRUNS = 256
) (
  input  logic                  pclk,
  input  logic                  preset_n,
  input  logic                  enable,
  input  logic [1:0]            oversampling_x,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_l,
  input  logic [31:0]           in_r,
  output logic                  start,
  output logic [31:0]           x_0,
  output logic [31:0]           x_1,
  output logic                  underrun,
  output logic [DEPTH_LOG2:0]   level
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int LVL_W = DEPTH_LOG2 + 1;
  localparam int UC_W  = $clog2(STOP_UNDERRUNS + 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PREFILL = 2'd1,
    ST_RUN     = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [1:0]            osx_q, osx_d;
  logic [9:0]            cnt_q, cnt_d;
  logic [UC_W-1:0]       ucnt_q, ucnt_d;
  logic                  start_q, start_d;
  logic [31:0]           x0_q, x0_d;
  logic [31:0]           x1_q, x1_d;
  logic                  und_q, und_d;
  logic [LVL_W-1:0]      lvl_q, lvl_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic                  rdy_q, rdy_d;

  logic                  push_s;
  logic                  pop_s;
  logic                  flush_s;
  logic [63:0]           head_s;
  logic [10:0]           period_s;
  logic [9:0]            period_last_s;

  logic [63:0]           mem_q [DEPTH];

  assign head_s        = mem_q[rd_ptr_q];
  assign period_s      = 11'd128 << osx_q;
  assign period_last_s = 10'(period_s - 11'd1);

  // Next-state logic for the sequencer, FIFO bookkeeping and output registers.
  always_comb begin
    state_d  = state_q;
    osx_d    = osx_q;
    cnt_d    = cnt_q;
    ucnt_d   = ucnt_q;
    start_d  = start_q;
    x0_d     = x0_q;
    x1_d     = x1_q;
    und_d    = und_q;
    push_s   = in_valid && rdy_q;
    pop_s    = 1'b0;
    flush_s  = 1'b0;

    if (!enable) begin
      state_d = ST_IDLE;
      start_d = 1'b0;
      x0_d    = 32'd0;
      x1_d    = 32'd0;
      cnt_d   = 10'd0;
      flush_s = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          flush_s = 1'b1;
          start_d = 1'b0;
          x0_d    = 32'd0;
          x1_d    = 32'd0;
          cnt_d   = 10'd0;
          und_d   = 1'b0;
          ucnt_d  = '0;
          state_d = ST_PREFILL;
          osx_d   = oversampling_x;
        end
        ST_PREFILL: begin
          cnt_d = 10'd0;
          if (lvl_q >= LVL_W'(PREFILL)) begin
            pop_s   = 1'b1;
            x0_d    = head_s[63:32];
            x1_d    = head_s[31:0];
            start_d = 1'b1;
            state_d = ST_RUN;
          end else begin
            start_d = 1'b0;
          end
        end
        ST_RUN: begin
          if (ucnt_q >= UC_W'(STOP_UNDERRUNS)) begin
            state_d = ST_IDLE;
            start_d = 1'b0;
            x0_d    = 32'd0;
            x1_d    = 32'd0;
            cnt_d   = 10'd0;
            flush_s = 1'b1;
          end else if (cnt_q == period_last_s) begin
            // Pop on the edge after the load slot so x is stable while the FIR samples it.
            cnt_d = 10'd0;
            if (lvl_q != LVL_W'(0)) begin
              pop_s  = 1'b1;
              x0_d   = head_s[63:32];
              x1_d   = head_s[31:0];
              ucnt_d = '0;
            end else begin
              und_d  = 1'b1;
              ucnt_d = ucnt_q + UC_W'(1);
`ifdef HOLD_LAST_EN
              x0_d   = x0_q;
              x1_d   = x1_q;
`else
              x0_d   = 32'd0;
              x1_d   = 32'd0;
`endif
            end
          end else begin
            cnt_d = cnt_q + 10'd1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          start_d = 1'b0;
          x0_d    = 32'd0;
          x1_d    = 32'd0;
          cnt_d   = 10'd0;
          flush_s = 1'b1;
        end
      endcase
    end

    if (flush_s) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      lvl_d    = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(push_s);
      rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(pop_s);
      lvl_d    = lvl_q + LVL_W'(push_s) - LVL_W'(pop_s);
    end

    rdy_d = enable && (state_d != ST_IDLE) && (lvl_d < LVL_W'(DEPTH));
  end

  // State and output registers.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_q  <= ST_IDLE;
      osx_q    <= 2'd0;
      cnt_q    <= 10'd0;
      ucnt_q   <= '0;
      start_q  <= 1'b0;
      x0_q     <= 32'd0;
      x1_q     <= 32'd0;
      und_q    <= 1'b0;
      lvl_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      osx_q    <= osx_d;
      cnt_q    <= cnt_d;
      ucnt_q   <= ucnt_d;
      start_q  <= start_d;
      x0_q     <= x0_d;
      x1_q     <= x1_d;
      und_q    <= und_d;
      lvl_q    <= lvl_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      rdy_q    <= rdy_d;
    end
  end

  // Sample storage; contents are only meaningful below the level count.
  always_ff @(posedge pclk) begin
    if (push_s && !flush_s) begin
      mem_q[wr_ptr_q] <= {in_l, in_r};
    end
  end

  assign in_ready = rdy_q;
  assign start    = start_q;
  assign x_0      = x0_q;
  assign x_1      = x1_q;
  assign underrun = und_q;
  assign level    = lvl_q;

endmodule
